tick_gen_multi: RTL and testbench

Multi-channel programmable timebase generator: NUM_CH independent down-counted periods, each producing a single-clock-cycle `tick` pulse. Each channel runs periodic or one-shot, with a run-time programmable period. Sits beside the display/LED logic as the shared source of 0.5 s / 1 s / scan-rate strobes, replacing per-function fixed-period counters.

---
 rtl/tick_gen_multi.sv | 140 ++++++++++++++
 tb/tb_tick_gen_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent programmable tick generators, periodic or one-shot.
// Define TICK_GEN_PRESCALE_EN to advance all channel counters from a shared 1/PRESC strobe.
module tick_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(25_000_000),
  parameter int PRESC = 50,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic              adv;
  logic [NUM_CH-1:0] cfg_hit;

  // An out-of-range cfg_ch matches no channel, so the write is silently dropped.
  always_comb begin
    cfg_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_hit[c] = cfg_we && (int'(cfg_ch) == c);
    end
  end

`ifdef TICK_GEN_PRESCALE_EN
  localparam int PS_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC - 1);

  logic [PS_W-1:0] ps_cnt;

  // Restarting the prescaler with sync_clr/config keeps the first period full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (sync_clr || (|cfg_hit) || (ps_cnt == PS_LAST)) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign adv = (ps_cnt == PS_LAST);
`else
  logic unused_presc;
  assign unused_presc = (PRESC != 0);
  assign adv = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             mode;
    logic [1:0]       state;
    logic             tick_q;
    logic             busy_q;

    // A period of 0 is treated as 1, so the terminal count is never below 0.
    assign last = (period == '0) ? '0 : period - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        period <= DEFAULT_PERIOD;
        mode   <= 1'b0;
        cnt    <= '0;
        state  <= ST_IDLE;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (cfg_hit[i]) begin
        period <= cfg_period;
        mode   <= cfg_oneshot;
        cnt    <= '0;
        state  <= ST_IDLE;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (!ch_en[i]) begin
        cnt    <= '0;
        state  <= ST_IDLE;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (sync_clr) begin
        cnt    <= '0;
        state  <= ST_RUN;
        tick_q <= 1'b0;
        busy_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt    <= '0;
            state  <= ST_RUN;
            tick_q <= 1'b0;
            busy_q <= 1'b1;
          end
          ST_RUN: begin
            if (!adv) begin
              tick_q <= 1'b0;
            end else if (cnt == last) begin
              cnt    <= '0;
              tick_q <= 1'b1;
              if (mode) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
              end
            end else begin
              cnt    <= cnt + CNT_W'(1);
              tick_q <= 1'b0;
            end
          end
          ST_DONE: begin
            cnt    <= '0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
          end
          default: begin
            cnt    <= '0;
            state  <= ST_IDLE;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end

    assign tick[i] = tick_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed scoreboard bench for tick_gen_multi; expected tick/busy per edge
// is derived from each channel's start edge, period and mode.
module tb_tick_gen_multi;

  localparam int NCH = 3;
  localparam int CW = 32;
  localparam int CHW = 2;
  localparam int PRESC = 3;
  localparam int DEF_P = 25_000_000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic           cfg_oneshot;
  logic           sync_clr;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  tick_gen_multi #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .DEFAULT_PERIOD(32'd25_000_000),
    .PRESC(PRESC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_en(ch_en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .sync_clr(sync_clr),
    .tick(tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [NCH-1:0] exp_tick_q[$];
  logic [NCH-1:0] exp_busy_q[$];
  string          tag_q[$];
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int e0[NCH];
  int pe[NCH];
  bit os[NCH];

  // Expected outputs after edge e: a channel started (RUN entered) at e0 with period pe.
  function automatic void expAt(input int e, output logic [NCH-1:0] t, output logic [NCH-1:0] b);
    int j;
    int len;
    t = '0;
    b = '0;
    for (int c = 0; c < NCH; c++) begin
      if (e0[c] >= 0 && e >= e0[c]) begin
        j = e - e0[c];
`ifdef TICK_GEN_PRESCALE_EN
        len = PRESC * pe[c];
        if (os[c]) begin
          b[c] = (j + 1 < len);
          t[c] = (j + 1 == len);
        end else begin
          b[c] = 1'b1;
          t[c] = (j >= 1) && ((j + 1) % len == 0);
        end
`else
        len = pe[c];
        if (os[c]) begin
          b[c] = (j < len);
          t[c] = (j == len);
        end else begin
          b[c] = 1'b1;
          t[c] = (j >= 1) && (j % len == 0);
        end
`endif
      end
    end
  endfunction

  task automatic pushExp(input string tag, input logic [NCH-1:0] t, input logic [NCH-1:0] b);
    exp_tick_q.push_back(t);
    exp_busy_q.push_back(b);
    tag_q.push_back(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic [NCH-1:0] en, input logic we,
                               input logic [CHW-1:0] ch, input logic [CW-1:0] p,
                               input logic osm, input logic sclr);
    logic [NCH-1:0] t;
    logic [NCH-1:0] b;
    ch_en = en;
    cfg_we = we;
    cfg_ch = ch;
    cfg_period = p;
    cfg_oneshot = osm;
    sync_clr = sclr;
    expAt(edge_n + 1, t, b);
    pushExp(tag, t, b);
  endtask

  task automatic checkOutput(input bit at_edge);
    logic [NCH-1:0] et;
    logic [NCH-1:0] eb;
    string tg;
    if (at_edge) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
    et = exp_tick_q.pop_front();
    eb = exp_busy_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (tick === et) else begin
      failures++;
      $error("[TB] FAIL %s tick observed=%b expected=%b (edge %0d)", tg, tick, et, edge_n);
    end
    checks++;
    assert (busy === eb) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%b expected=%b (edge %0d)", tg, busy, eb, edge_n);
    end
  endtask

  task automatic trackEnable(input logic [NCH-1:0] en);
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) e0[c] = -1;
      else if (!ch_en[c]) e0[c] = edge_n + 1;
    end
  endtask

  task automatic setEnable(input string tag, input logic [NCH-1:0] en);
    trackEnable(en);
    applyStimulus(tag, en, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput(1'b1);
  endtask

  task automatic cfgWrite(input string tag, input int ch, input int p, input bit osm,
                          input logic [NCH-1:0] en);
    trackEnable(en);
    e0[ch] = en[ch] ? edge_n + 2 : -1;
    pe[ch] = (p < 1) ? 1 : p;
    os[ch] = osm;
    applyStimulus(tag, en, 1'b1, CHW'(ch), CW'(p), osm, 1'b0);
    checkOutput(1'b1);
  endtask

  task automatic runCycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(tag, ch_en, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput(1'b1);
    end
  endtask

  task automatic syncClear(input string tag);
    for (int c = 0; c < NCH; c++) begin
      if (ch_en[c]) e0[c] = edge_n + 1;
    end
    applyStimulus(tag, ch_en, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput(1'b1);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic asyncResetPulse(input string tag);
    #2;
    rst_n = 1'b0;
    ch_en = '0;
    cfg_we = 1'b0;
    sync_clr = 1'b0;
    #1;
    pushExp(tag, '0, '0);
    checkOutput(1'b0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      e0[c] = -1;
      pe[c] = DEF_P;
      os[c] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1;
    ch_en = '0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_period = '0;
    cfg_oneshot = 1'b0;
    sync_clr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      e0[c] = -1;
      pe[c] = DEF_P;
      os[c] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pushExp("reset_state", '0, '0);
    checkOutput(1'b0);
    #2 rst_n = 1'b1;
    runCycles("idle_after_reset", 3);

`ifdef TICK_GEN_PRESCALE_EN
    cfgWrite("pre_cfg", 0, 2, 1'b0, 3'b001);
    runCycles("pre_run", 14);
    asyncResetPulse("pre_async_reset");
    runCycles("pre_idle_after_reset", 2);
    cfgWrite("pre_cfg2", 0, 2, 1'b0, 3'b001);
    runCycles("pre_restart", 8);
`else
    cfgWrite("ch0_p5_cfg", 0, 5, 1'b0, 3'b001);
    runCycles("ch0_p5", 16);
    setEnable("ch0_off", 3'b000);

    cfgWrite("ch1_os_cfg", 1, 3, 1'b1, 3'b010);
    runCycles("ch1_oneshot", 55);
    setEnable("ch1_off", 3'b000);
    setEnable("ch1_rearm", 3'b010);
    runCycles("ch1_oneshot2", 6);
    setEnable("ch1_off2", 3'b000);

    cfgWrite("ch2_p0_cfg", 2, 0, 1'b0, 3'b100);
    runCycles("ch2_p0", 6);
    cfgWrite("ch2_p1_cfg", 2, 1, 1'b0, 3'b100);
    runCycles("ch2_p1", 6);
    cfgWrite("ch2_p2_cfg", 2, 2, 1'b0, 3'b100);
    runCycles("ch2_p2", 8);
    setEnable("ch2_off", 3'b000);

    // The write lands on the terminal-count edge, so that tick must never appear.
    cfgWrite("ch0_tc_cfg", 0, 5, 1'b0, 3'b001);
    runCycles("ch0_pre_tc", 5);
    cfgWrite("ch0_tc_write", 0, 3, 1'b0, 3'b001);
    runCycles("ch0_p3", 4);
    applyStimulus("bad_ch_write", 3'b001, 1'b1, 2'd3, 32'd7, 1'b1, 1'b0);
    checkOutput(1'b1);
    runCycles("ch0_after_bad", 8);

    setEnable("all_off", 3'b000);
    cfgWrite("ch0_p4_cfg", 0, 4, 1'b0, 3'b000);
    cfgWrite("ch2_p6_cfg", 2, 6, 1'b0, 3'b000);
    setEnable("ch1_start", 3'b010);
    setEnable("ch0_start", 3'b011);
    setEnable("ch2_start", 3'b111);
    runCycles("phased", 6);
    syncClear("sync");
    runCycles("after_sync", 13);

    setEnable("all_off2", 3'b000);
    cfgWrite("ch2_p1_again", 2, 1, 1'b0, 3'b100);
    runCycles("ch2_run", 3);
    asyncResetPulse("async_reset");
    setEnable("post_reset_en", 3'b001);
    runCycles("default_period", 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
